// File: rtl/scroll_display_ctrl_if.sv
// Value handshake between a producer and the scrolling display controller.
// The producer offers in_data with in_valid; the controller answers with in_ready.
interface scroll_display_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/scroll_display_ctrl.sv
// Signed value to multiplexed 7-segment display with sequential BCD conversion,
// horizontal scrolling over the digits, a sign position and leading-zero blanking.
module scroll_display_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned BCD_DIGITS  = 5,
    parameter int unsigned NUM_AN      = 4,
    parameter int unsigned REFRESH_DIV = 250000,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    scroll_display_ctrl_if.slave  bus,
    input  logic                  scroll_left,
    input  logic                  scroll_right,
    input  logic                  clr,
    output logic                  busy,
    output logic [6:0]            segments,
    output logic [NUM_AN-1:0]     anode
);

    localparam int unsigned BCD_W   = 4 * BCD_DIGITS;
    localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
    localparam int unsigned MAX_OFF = BCD_DIGITS - (NUM_AN - 1);
    localparam int unsigned OFF_W   = (MAX_OFF > 0) ? $clog2(MAX_OFF + 1) : 1;
    localparam int unsigned IDX_W   = $clog2(NUM_AN);
    localparam int unsigned REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;

    function automatic logic [127:0] pow10(input int unsigned n);
        logic [127:0] r;
        r = 128'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 128'd10;
        return r;
    endfunction

    // The digit count must hold the largest magnitude, 2^(DATA_W-1).
    if (pow10(BCD_DIGITS) <= (128'd1 << (DATA_W - 1))) begin : g_bcd_too_small
        $error("scroll_display_ctrl: BCD_DIGITS too small for DATA_W");
    end
    if (NUM_AN < 2 || NUM_AN > BCD_DIGITS + 1) begin : g_bad_num_an
        $error("scroll_display_ctrl: NUM_AN out of range");
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0001100;
            default: return SEG_BLANK;
        endcase
    endfunction

    typedef enum logic [0:0] {ST_IDLE, ST_CONV} state_t;

    state_t            state;
    logic [CNT_W-1:0]  iter;
    logic [DATA_W-1:0] bin;
    logic [BCD_W-1:0]  bcd;
    logic              sign_pend;
    logic [BCD_W-1:0]  disp_bcd;
    logic              disp_neg;
    logic [OFF_W-1:0]  offset;
    logic [REF_W-1:0]  ref_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic              step_q;

    logic [DATA_W-1:0] mag_c;
    logic [BCD_W-1:0]  bcd_adj_c;
    logic [BCD_W-1:0]  bcd_nxt_c;
    logic [DATA_W-1:0] bin_nxt_c;
    logic [BCD_DIGITS-1:0] blank_c;
    logic [3:0]        digit_c;
    logic [6:0]        seg_c;

    // Two's-complement negation also maps the most negative value onto its unsigned magnitude.
    always_comb begin
        mag_c = bus.in_data;
        if (bus.in_data[DATA_W-1]) mag_c = ~bus.in_data + DATA_W'(1);
    end

    // One double-dabble iteration: correct nibbles >= 5, then shift the whole word left.
    always_comb begin
        bcd_adj_c = bcd;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_nxt_c = {bcd_adj_c[BCD_W-2:0], bin[DATA_W-1]};
        bin_nxt_c = {bin[DATA_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            bus.in_ready <= 1'b1;
            iter         <= '0;
            bin          <= '0;
            bcd          <= '0;
            sign_pend    <= 1'b0;
            disp_bcd     <= '0;
            disp_neg     <= 1'b0;
        end else if (clr) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            bus.in_ready <= 1'b1;
            iter         <= '0;
            disp_bcd     <= '0;
            disp_neg     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        state        <= ST_CONV;
                        busy         <= 1'b1;
                        bus.in_ready <= 1'b0;
                        iter         <= '0;
                        bin          <= mag_c;
                        bcd          <= '0;
                        sign_pend    <= bus.in_data[DATA_W-1];
                    end
                end
                ST_CONV: begin
                    bin  <= bin_nxt_c;
                    bcd  <= bcd_nxt_c;
                    iter <= iter + CNT_W'(1);
                    if (iter == CNT_W'(DATA_W - 1)) begin
                        state        <= ST_IDLE;
                        busy         <= 1'b0;
                        bus.in_ready <= 1'b1;
                        disp_bcd     <= bcd_nxt_c;
                        disp_neg     <= sign_pend && (bcd_nxt_c != '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Scroll offset saturates at both ends; simultaneous pulses cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset <= '0;
        end else if (clr) begin
            offset <= '0;
        end else if (scroll_left && !scroll_right) begin
            if (offset < OFF_W'(MAX_OFF)) offset <= offset + OFF_W'(1);
        end else if (scroll_right && !scroll_left) begin
            if (offset != '0) offset <= offset - OFF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt  <= '0;
            scan_idx <= '0;
            step_q   <= 1'b0;
        end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt  <= '0;
            scan_idx <= (scan_idx == IDX_W'(NUM_AN - 1)) ? '0 : scan_idx + IDX_W'(1);
            step_q   <= 1'b1;
        end else begin
            ref_cnt  <= ref_cnt + REF_W'(1);
            step_q   <= 1'b0;
        end
    end

    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        blank_c = '0;
        for (int i = int'(BCD_DIGITS) - 1; i >= 0; i--) begin
            if (disp_bcd[4*i +: 4] != 4'd0) seen = 1'b1;
            blank_c[i] = !seen && (i != 0) && (BLANK_LZ != 0);
        end
    end

    always_comb begin
        int di;
        logic blank;
        di      = int'(offset) + int'(scan_idx);
        digit_c = 4'd0;
        blank   = 1'b0;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (i == di) begin
                digit_c = disp_bcd[4*i +: 4];
                blank   = blank_c[i];
            end
        end
        if (scan_idx == IDX_W'(NUM_AN - 1)) seg_c = disp_neg ? SEG_MINUS : SEG_BLANK;
        else if (blank)                     seg_c = SEG_BLANK;
        else                                seg_c = seg_decode(digit_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segments <= SEG_BLANK;
            anode    <= '1;
        end else if (step_q) begin
            segments <= seg_c;
            anode    <= ~(NUM_AN'(1) << scan_idx);
        end
    end

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Bench for scroll_display_ctrl: directed and random values checked against a
// decimal-arithmetic model of what each anode position should show.
module tb_scroll_display_ctrl;

    localparam int DATA_W = 16;
    localparam int BCD_D  = 5;
    localparam int NUM_AN = 4;
    localparam int RDIV   = 4;
    localparam int MAXOFF = BCD_D - (NUM_AN - 1);

    logic clk = 1'b0;
    logic rst;
    logic scroll_left, scroll_right, clr, busy;
    logic [6:0] segments;
    logic [NUM_AN-1:0] anode;

    always #5 clk = ~clk;

    scroll_display_ctrl_if #(.DATA_W(DATA_W)) bus ();

    scroll_display_ctrl #(
        .DATA_W(DATA_W), .BCD_DIGITS(BCD_D), .NUM_AN(NUM_AN),
        .REFRESH_DIV(RDIV), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .scroll_left(scroll_left), .scroll_right(scroll_right), .clr(clr),
        .busy(busy), .segments(segments), .anode(anode)
    );

    int compared   = 0;
    int mismatched = 0;

    int m_mag = 0;
    bit m_neg = 1'b0;
    int m_off = 0;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_seg(input int k);
        int i, p, d;
        if (k == NUM_AN - 1) return m_neg ? 7'b1111110 : 7'b1111111;
        i = m_off + k;
        p = 10 ** i;
        d = (m_mag / p) % 10;
        if (i > 0 && m_mag < p) return 7'b1111111;
        return seg_tab[d];
    endfunction

    function automatic void set_model(input int v);
        m_mag = (v < 0) ? -v : v;
        m_neg = (v < 0);
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        chk({tag, "_busy_len"}, 32'(n), 32'd16);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic send(input int v, input string tag);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'(v);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_accepted"}, 32'(busy), 32'd1);
        wait_idle(tag);
        set_model(v);
    endtask

    task automatic scroll(input bit l, input bit r);
        scroll_left  = l;
        scroll_right = r;
        step();
        scroll_left  = 1'b0;
        scroll_right = 1'b0;
        if (l && !r && m_off < MAXOFF) m_off++;
        if (r && !l && m_off > 0) m_off--;
    endtask

    task automatic check_display(input string tag);
        logic [NUM_AN-1:0] exp_an;
        logic [6:0] exp_s;
        repeat (2 * NUM_AN * RDIV) step();
        for (int k = 0; k < NUM_AN; k++) begin
            int n = 0;
            exp_an = ~(NUM_AN'(1) << k);
            while (anode !== exp_an && n < 40) begin
                n++;
                step();
            end
            exp_s = exp_seg(k);
            chk($sformatf("%s_an%0d", tag, k), 32'(anode), 32'(exp_an));
            chk($sformatf("%s_seg%0d", tag, k), 32'(segments), 32'(exp_s));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_AN-1:0] rot [5];
        int n;
        int v;
        rot = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        rst = 1'b1;
        clr = 1'b0;
        scroll_left = 1'b0;
        scroll_right = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        step();
        step();
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_seg", 32'(segments), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        step();
        chk("post_rst_anode", 32'(anode), 32'hF);
        check_display("zero_init");

        send(1234, "v1234");
        check_display("v1234_off0");
        scroll(1'b1, 1'b0);
        check_display("v1234_off1");

        send(-32768, "vmin");
        scroll(1'b1, 1'b0);
        scroll(1'b1, 1'b0);
        check_display("vmin_off2");
        chk("vmin_sat_off", 32'(m_off), 32'd2);

        scroll(1'b0, 1'b1);
        scroll(1'b1, 1'b1);
        check_display("both_off1");

        // Anode rotation every RDIV cycles
        n = 0;
        while (anode !== 4'b1110 && n < 40) begin
            n++;
            step();
        end
        for (int i = 1; i < 5; i++) begin
            repeat (RDIV) step();
            chk($sformatf("rot%0d", i), 32'(anode), 32'(rot[i]));
        end

        scroll(1'b0, 1'b1);
        scroll(1'b0, 1'b1);
        send(7, "v7");
        check_display("v7");
        send(0, "v0");
        check_display("v0");

        // Value offered while busy is held off until in_ready returns
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd99;
        step();
        bus.in_data  = 16'd5;
        chk("hold_busy", 32'(busy), 32'd1);
        wait_idle("hold99");
        step();
        bus.in_valid = 1'b0;
        chk("hold_5_accepted", 32'(busy), 32'd1);
        wait_idle("hold5");
        set_model(5);
        check_display("hold5");

        // clr during conversion cycle 8
        scroll(1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd12345;
        step();
        bus.in_valid = 1'b0;
        repeat (7) step();
        chk("clr_pre_busy", 32'(busy), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_ready", 32'(bus.in_ready), 32'd1);
        set_model(0);
        m_off = 0;
        check_display("clr");

        // rst mid-conversion, then immediate acceptance
        scroll(1'b1, 1'b0);
        scroll(1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'(-4321);
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_anode", 32'(anode), 32'hF);
        step();
        rst = 1'b0;
        m_off = 0;
        send(42, "after_rst");
        check_display("after_rst");

        // Random values and scrolls
        for (int t = 0; t < 8; t++) begin
            v = int'($urandom_range(0, 65535)) - 32768;
            send(v, $sformatf("rnd%0d", t));
            repeat ($urandom_range(0, 3)) scroll(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_display($sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
